icache_ctrl: RTL and testbench

- Fetch-side controller for the L1 instruction cache; sits directly upstream of the icache tag/data store and drives its enable/comp/write/tag/index/offset/data_in lines.
- Accepts one 8-byte instruction fetch at a time and looks it up in the store.
- On a miss, requests the 64-byte line from the next memory level, writes the eight returned words into the store as fills, then returns the instruction to the fetch unit.

---
 rtl/icache_ctrl_pkg.sv | 25 ++
 rtl/icache_fill_seq.sv | 33 +++
 rtl/icache_ctrl.sv | 118 +++++++++++
 tb/tb_icache_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_ctrl_pkg.sv
// icache_ctrl_pkg: shared mem_sys constants, controller state encodings and fill-offset helper
package icache_ctrl_pkg;
  localparam int L1_TAG_WIDTH = 6;
  localparam int L1_INDEX_WIDTH = 4;
  localparam int L1_OFFSET_WIDTH = 6;
  localparam int L1_ICACHE_DATA_WIDTH = 64;
  localparam int L1_ADDR_WIDTH = L1_TAG_WIDTH + L1_INDEX_WIDTH + L1_OFFSET_WIDTH;
  localparam int L1_LINE_WORDS = 8;
  localparam int L1_WORD_BITS = $clog2(L1_LINE_WORDS);
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOOKUP = 3'd1;
  localparam logic [2:0] ST_MEM_REQ = 3'd2;
  localparam logic [2:0] ST_FILL = 3'd3;
  localparam logic [2:0] ST_RESP = 3'd4;
  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    LOOKUP = ST_LOOKUP,
    MEM_REQ = ST_MEM_REQ,
    FILL = ST_FILL,
    RESP = ST_RESP
  } state_t;
  function automatic logic [L1_OFFSET_WIDTH-1:0] word_offset(input logic [L1_WORD_BITS-1:0] w);
    return {w, 3'b000};
  endfunction
endpackage

// File: rtl/icache_fill_seq.sv
// icache_fill_seq: line-fill beat sequencer (word pointer with wrap, beat count, store offset)
module icache_fill_seq
  import icache_ctrl_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic [L1_WORD_BITS-1:0]    start_word,
  input  logic                       beat,
  output logic [L1_OFFSET_WIDTH-1:0] offset,
  output logic                       first,
  output logic                       last
);
  logic [L1_WORD_BITS-1:0] word_q, word_d, cnt_q, cnt_d;
  // word pointer wraps mod 8 from the start word; cnt tracks beats independently of the start
  always_comb begin
    word_d = load ? start_word : beat ? word_q + 1'b1 : word_q;
    cnt_d = load ? '0 : beat ? cnt_q + 1'b1 : cnt_q;
  end
  // sequencer state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
      cnt_q <= '0;
    end else begin
      word_q <= word_d;
      cnt_q <= cnt_d;
    end
  end
  assign offset = word_offset(word_q);
  assign first = beat && cnt_q == '0;
  assign last = beat && cnt_q == L1_WORD_BITS'(L1_LINE_WORDS - 1);
endmodule

// File: rtl/icache_ctrl.sv
// icache_ctrl: L1 icache fetch controller (lookup, line refill, response); ICACHE_CRITICAL_WORD_FIRST_EN enables wrap-order fill with early response
module icache_ctrl
  import icache_ctrl_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_valid,
  input  logic [L1_ADDR_WIDTH-1:0]        req_addr,
  output logic                            req_ready,
  output logic                            rsp_valid,
  output logic [L1_ICACHE_DATA_WIDTH-1:0] rsp_data,
  output logic                            rsp_err,
  output logic                            mem_req_valid,
  output logic [L1_ADDR_WIDTH-1:0]        mem_req_addr,
  input  logic                            mem_req_ready,
  input  logic                            mem_rsp_valid,
  input  logic [L1_ICACHE_DATA_WIDTH-1:0] mem_rsp_data,
  output logic                            st_enable,
  output logic                            st_comp,
  output logic                            st_write,
  output logic                            st_valid_in,
  output logic [L1_TAG_WIDTH-1:0]         st_tag,
  output logic [L1_INDEX_WIDTH-1:0]       st_index,
  output logic [L1_OFFSET_WIDTH-1:0]      st_offset,
  output logic [L1_ICACHE_DATA_WIDTH-1:0] st_data_in,
  input  logic                            st_hit,
  input  logic                            st_valid,
  input  logic                            st_err,
  input  logic [L1_ICACHE_DATA_WIDTH-1:0] st_data_out
);
  state_t state_q, state_d;
  logic [L1_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [L1_OFFSET_WIDTH-1:0] fill_off;
  logic [L1_WORD_BITS-1:0] start_word;
  logic load, beat, first, last, found;
  assign req_ready = state_q == IDLE;
  assign mem_req_valid = state_q == MEM_REQ;
  assign load = mem_req_valid && mem_req_ready;
  assign beat = state_q == FILL && mem_rsp_valid;
  assign found = st_err || (st_hit && st_valid);
  assign st_tag = addr_q[L1_ADDR_WIDTH-1 -: L1_TAG_WIDTH];
  assign st_index = addr_q[L1_OFFSET_WIDTH +: L1_INDEX_WIDTH];
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
  assign start_word = addr_q[5:3];
  assign mem_req_addr = {addr_q[L1_ADDR_WIDTH-1:L1_OFFSET_WIDTH], word_offset(start_word)};
`else
  assign start_word = '0;
  assign mem_req_addr = {addr_q[L1_ADDR_WIDTH-1:L1_OFFSET_WIDTH], {L1_OFFSET_WIDTH{1'b0}}};
`endif
  icache_fill_seq u_fill_seq (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .start_word (start_word),
    .beat       (beat),
    .offset     (fill_off),
    .first      (first),
    .last       (last)
  );
  // next state, store drive and response muxing
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    rsp_valid = 1'b0;
    rsp_err = 1'b0;
    rsp_data = '0;
    st_enable = 1'b0;
    st_comp = 1'b0;
    st_write = 1'b0;
    st_valid_in = 1'b0;
    st_offset = addr_q[L1_OFFSET_WIDTH-1:0];
    st_data_in = '0;
    unique case (state_q)
      IDLE: begin
        addr_d = req_valid ? req_addr : addr_q;
        state_d = req_valid ? LOOKUP : IDLE;
      end
      LOOKUP, RESP: begin
        st_enable = 1'b1;
        st_comp = 1'b1;
        rsp_valid = found || state_q == RESP;
        rsp_err = st_err;
        rsp_data = rsp_valid && !st_err ? st_data_out : '0;
        state_d = rsp_valid ? IDLE : MEM_REQ;
      end
      MEM_REQ: state_d = mem_req_ready ? FILL : MEM_REQ;
      FILL: begin
        st_enable = beat;
        st_write = beat;
        st_valid_in = beat;
        st_offset = fill_off;
        st_data_in = beat ? mem_rsp_data : '0;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
        rsp_valid = first;
        rsp_data = first ? mem_rsp_data : '0;
        state_d = last ? IDLE : FILL;
`else
        state_d = last ? RESP : FILL;
`endif
      end
      default: state_d = IDLE;
    endcase
  end
  // controller state and request register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
    end
  end
  // a re-lookup after a complete fill can only hit
  always_ff @(posedge clk) begin
    if (!rst && state_q == RESP) assert (st_hit && st_valid);
  end
endmodule

// File: tb/tb_icache_ctrl.sv
// tb_icache_ctrl: randomized fetch stream against a line-presence reference model, scoreboarded response monitor
`timescale 1ns/1ps
module tb_icache_ctrl;
  import icache_ctrl_pkg::*;
  localparam int AW = L1_ADDR_WIDTH;
  localparam int NS = 1 << L1_INDEX_WIDTH;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif
  typedef struct {
    logic [63:0] data;
    logic err;
    logic hit;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_ready, rsp_valid, rsp_err;
  logic [AW-1:0] req_addr = '0, mem_req_addr;
  logic [63:0] rsp_data, mem_rsp_data = '0, st_data_in, st_data_out;
  logic mem_req_valid, mem_req_ready = 1'b0, mem_rsp_valid = 1'b0;
  logic st_enable, st_comp, st_write, st_valid_in, st_hit, st_valid, st_err;
  logic [L1_TAG_WIDTH-1:0] st_tag;
  logic [L1_INDEX_WIDTH-1:0] st_index;
  logic [L1_OFFSET_WIDTH-1:0] st_offset;

  int total = 0, bad = 0, cyc = 0;
  exp_t q[$];
  logic m_vld[NS];
  logic [L1_TAG_WIDTH-1:0] m_tag[NS];
  int cfg_delay = 0, cfg_gap = 0;
  logic [2:0] cfg_start = '0;
  logic [AW-1:0] exp_mreq = '0;
  int mreq_cnt = 0, acc_cyc = 0, acc_mreq = 0;
  int r_phase = 0, dly = 0, gap = 0, nb = 0, first_cyc = 0, last_cyc = 0;
  logic [2:0] cur_w = '0;

  logic s_vld[NS];
  logic [L1_TAG_WIDTH-1:0] s_tag[NS];
  logic [63:0] s_data[NS][8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  icache_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .st_enable(st_enable), .st_comp(st_comp), .st_write(st_write), .st_valid_in(st_valid_in),
    .st_tag(st_tag), .st_index(st_index), .st_offset(st_offset), .st_data_in(st_data_in),
    .st_hit(st_hit), .st_valid(st_valid), .st_err(st_err), .st_data_out(st_data_out)
  );

  // tag/data store: direct mapped, cleared by the same reset
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NS; i++) s_vld[i] <= 1'b0;
    end else if (st_enable && st_write) begin
      s_data[st_index][st_offset[5:3]] <= st_data_in;
      s_tag[st_index] <= st_tag;
      s_vld[st_index] <= st_valid_in;
    end
  end
  always_comb begin
    st_hit = st_enable && s_vld[st_index] && s_tag[st_index] == st_tag;
    st_valid = st_enable && s_vld[st_index];
    st_err = st_enable && st_offset[2:0] != 3'd0;
    st_data_out = s_data[st_index][st_offset[5:3]];
  end

  // backing memory contents: line 0x40 holds 0xA0..0xA7
  function automatic logic [63:0] mword(input logic [AW-1:0] a);
    return (a[AW-1:6] == 1) ? 64'hA0 + 64'(a[5:3]) : {16'hC0DE, 16'(a), 32'(a) * 32'h9E3779B9};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // next-level memory: accepts after cfg_delay cycles, returns 8 beats with cfg_gap idle cycles between
  initial forever begin
    @(posedge clk);
    #1;
    if (rst) begin
      r_phase = 0;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
    end else begin
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      if (r_phase == 0 && mem_req_valid) begin
        dly = cfg_delay;
        r_phase = 1;
      end
      if (r_phase == 1) begin
        if (dly == 0) begin
          mem_req_ready = 1'b1;
          r_phase = 2;
        end else dly--;
      end else if (r_phase == 2) begin
        nb = 0;
        gap = 0;
        r_phase = 3;
      end
      if (r_phase == 3) begin
        if (gap > 0) gap--;
        else begin
          cur_w = cfg_start + 3'(nb);
          mem_rsp_valid = 1'b1;
          mem_rsp_data = mword({exp_mreq[AW-1:6], cur_w, 3'b000});
          if (nb == 0) first_cyc = cyc;
          last_cyc = cyc;
          nb++;
          gap = cfg_gap;
          if (nb == 8) r_phase = 4;
        end
      end else if (r_phase == 4) r_phase = 0;
    end
  end

  // monitor: store-port and memory-port checks every cycle, scoreboard pop on each response
  initial forever begin
    exp_t e;
    int want_cyc;
    @(negedge clk);
    if (!rst) begin
      if (req_valid && req_ready) begin
        acc_cyc = cyc;
        acc_mreq = mreq_cnt;
      end
      if (mem_req_valid) begin
        chk("mreq_addr", 64'(mem_req_addr), 64'(exp_mreq));
        if (mem_req_ready) mreq_cnt++;
      end
      if (mem_rsp_valid) begin
        chk("fill_ctl", 64'({st_enable, st_write, st_comp, st_valid_in}), 64'(4'b1101));
        chk("fill_off", 64'(st_offset), 64'({cur_w, 3'b000}));
        chk("fill_data", st_data_in, mem_rsp_data);
      end else if (r_phase == 3) chk("gap_enable", 64'(st_enable), 64'(0));
      if (st_enable && !mem_rsp_valid) chk("stray_write", 64'(st_write), 64'(0));
      if (rsp_valid) begin
        chk("rsp_vs_ready", 64'(req_ready), 64'(0));
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rsp: got data %0h expected no response (cycle %0d)", rsp_data, cyc);
        end else begin
          e = q.pop_front();
          chk("rsp_data", rsp_data, e.data);
          chk("rsp_err", 64'(rsp_err), 64'(e.err));
          want_cyc = (e.hit || e.err) ? acc_cyc + 1 : CWF ? first_cyc : last_cyc + 1;
          chk("rsp_cycle", 64'(cyc), 64'(want_cyc));
          chk("mem_req_count", 64'(mreq_cnt - acc_mreq), 64'((e.hit || e.err) ? 0 : 1));
        end
      end
    end
  end

  task automatic issue(input logic [AW-1:0] a, input int d, input int g);
    exp_t e;
    int n, idx;
    logic [L1_TAG_WIDTH-1:0] tg;
    n = 0;
    while (!req_ready && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("ready_wait", 64'(req_ready), 64'(1));
    cfg_delay = d;
    cfg_gap = g;
    cfg_start = CWF ? a[5:3] : 3'd0;
    exp_mreq = {a[AW-1:6], CWF ? a[5:3] : 3'd0, 3'd0};
    idx = int'(a[L1_OFFSET_WIDTH +: L1_INDEX_WIDTH]);
    tg = a[AW-1 -: L1_TAG_WIDTH];
    e.err = a[2:0] != 3'd0;
    e.hit = !e.err && m_vld[idx] && m_tag[idx] == tg;
    e.data = e.err ? 64'd0 : mword(a);
    if (!e.err) begin
      m_vld[idx] = 1'b1;
      m_tag[idx] = tg;
    end
    q.push_back(e);
    req_valid = 1'b1;
    req_addr = a;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr = AW'($urandom);
  endtask

  task automatic fetch(input logic [AW-1:0] a, input int d, input int g);
    int n;
    issue(a, d, g);
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("rsp_wait", 64'(q.size()), 64'(0));
    q.delete();
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] a;
    int n;
    for (int i = 0; i < NS; i++) m_vld[i] = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_req_ready", 64'(req_ready), 64'(1));
    chk("reset_outputs", 64'({rsp_valid, mem_req_valid, st_enable, st_write}), 64'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;
    fetch(16'h0040, 1, 0);
    fetch(16'h0048, 0, 0);
    fetch(16'h0043, 0, 0);
    fetch(16'h0480, 5, 2);
    issue(16'h0880, 0, 0);
    n = 0;
    while (!(nb == 3 && r_phase == 3) && n < 300) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("third_beat_wait", 64'(nb), 64'(3));
    @(posedge clk);
    #2;
    rst = 1'b1;
    q.delete();
    for (int i = 0; i < NS; i++) m_vld[i] = 1'b0;
    #1;
    chk("midfill_rst_ready", 64'(req_ready), 64'(1));
    chk("midfill_rst_idle", 64'({mem_req_valid, st_enable, rsp_valid}), 64'(0));
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 64'(req_ready), 64'(1));
    @(posedge clk);
    #1;
    fetch(16'h0880, 0, 1);
    fetch(16'h0078, 2, 0);
    fetch(16'h0040, 0, 0);
    for (int i = 0; i < 150; i++) begin
      a = {6'($urandom_range(0, 3)), 4'($urandom), 3'($urandom), 3'd0};
      if ($urandom_range(0, 7) == 0) a[2:0] = 3'($urandom_range(1, 7));
      fetch(a, $urandom_range(0, 3), $urandom_range(0, 2));
    end
    repeat (20) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
